// File: rtl/audio_seq_pkg.sv
// Shared types and helpers for the audio clip sequencer: FSM states,
// the silence sample value and the fixed-priority request picker.
package audio_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DESC,
    LOAD,
    WAIT,
    GAP
  } seq_state_t;

  localparam int SILENCE = 0;

  // Returns the index of the lowest set bit, or -1 when no bit is set.
  function automatic int pick_first(input logic [31:0] req);
    pick_first = -1;
    for (int i = 31; i >= 0; i--) begin
      if (req[i]) pick_first = i;
    end
  endfunction

endpackage

// File: rtl/clip_id_fifo.sv
// Synchronous FIFO holding queued clip IDs; clear empties it in one cycle.
module clip_id_fifo
  import audio_seq_pkg::*;
#(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == (PW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full & ~clear;
  assign do_pop  = pop & ~empty & ~clear;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/audio_clip_sequencer.sv
// Queues clip requests and streams each clip's samples from ROM to the CODEC.
// Optional AUDIO_SEQ_VOLUME_EN adds a 3-bit arithmetic-shift volume input.
module audio_clip_sequencer
  import audio_seq_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int CLIP_W      = 4,
  parameter int ADDR_W      = 16,
  parameter int SAMPLE_W    = 24,
  parameter int QUEUE_DEPTH = 4,
  parameter int GAP_SAMPLES = 480
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
`ifdef AUDIO_SEQ_VOLUME_EN
  input  logic [2:0]                    volume,
`endif
  input  logic [NUM_SRC-1:0]            req_valid,
  input  logic [NUM_SRC*CLIP_W-1:0]     req_clip,
  input  logic                          flush,
  input  logic [ADDR_W-1:0]             clip_base,
  input  logic [ADDR_W-1:0]             clip_len,
  output logic [ADDR_W-1:0]             rom_addr,
  input  logic [SAMPLE_W-1:0]           rom_data,
  input  logic                          codec_write_ready,
  output logic                          codec_write,
  output logic [SAMPLE_W-1:0]           codec_data,
  output logic [CLIP_W-1:0]             cur_clip,
  output logic                          busy,
  output logic                          clip_done,
  output logic [$clog2(QUEUE_DEPTH):0]  queue_level,
  output logic                          overflow
);

  localparam int GAP_W = (GAP_SAMPLES < 2) ? 1 : $clog2(GAP_SAMPLES + 1);

  seq_state_t          state, state_next;
  logic [ADDR_W-1:0]   remaining;
  logic [GAP_W-1:0]    gap_cnt;
  logic [SAMPLE_W-1:0] sample_reg;
  logic [2:0]          vol_reg;

  int                  win;
  int                  win_idx;
  logic [CLIP_W-1:0]   win_clip;
  logic                any_req;
  logic                multi_req;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CLIP_W-1:0]   fifo_dout;
  logic                fifo_push;
  logic                fifo_pop;

  always_comb begin
    win       = pick_first(32'(req_valid));
    win_idx   = (win < 0) ? 0 : win;
    win_clip  = req_clip[win_idx*CLIP_W +: CLIP_W];
    any_req   = |req_valid;
    multi_req = |(req_valid & (req_valid - 1'b1));
  end

  // Full is judged before any same-cycle pop, and flush drops the push silently.
  assign fifo_push = any_req & ~flush & ~fifo_full;
  assign fifo_pop  = (state == IDLE) & ~fifo_empty & ~flush;

  clip_id_fifo #(
    .W     (CLIP_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk   (CLOCK_50),
    .reset (reset),
    .clear (flush),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (win_clip),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (queue_level)
  );

  always_comb begin
    state_next = state;
    clip_done  = 1'b0;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (!fifo_empty) state_next = DESC;
        DESC: begin
          if (clip_len == '0) begin
            clip_done  = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = LOAD;
          end
        end
        LOAD: state_next = WAIT;
        WAIT: begin
          if (codec_write_ready) begin
            if (remaining == ADDR_W'(1)) begin
              clip_done  = 1'b1;
              state_next = (GAP_SAMPLES == 0) ? IDLE : GAP;
            end else begin
              state_next = LOAD;
            end
          end
        end
        GAP: if (codec_write_ready && gap_cnt == GAP_W'(1)) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= IDLE;
      rom_addr   <= '0;
      cur_clip   <= '0;
      sample_reg <= '0;
      remaining  <= '0;
      gap_cnt    <= '0;
      vol_reg    <= '0;
      overflow   <= 1'b0;
    end else begin
      state <= state_next;
      if (!flush && (multi_req || (any_req && fifo_full))) overflow <= 1'b1;
      if (!flush) begin
        case (state)
          IDLE: if (!fifo_empty) cur_clip <= fifo_dout;
          DESC: begin
            rom_addr  <= clip_base;
            remaining <= clip_len;
          end
          LOAD: begin
            sample_reg <= rom_data;
`ifdef AUDIO_SEQ_VOLUME_EN
            vol_reg    <= volume;
`else
            vol_reg    <= 3'd0;
`endif
          end
          WAIT: begin
            if (codec_write_ready) begin
              remaining <= remaining - 1'b1;
              if (remaining == ADDR_W'(1)) gap_cnt  <= GAP_W'(GAP_SAMPLES);
              else                         rom_addr <= rom_addr + 1'b1;
            end
          end
          GAP: if (codec_write_ready) gap_cnt <= gap_cnt - 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign codec_write = codec_write_ready &
                       ((state == IDLE) || (state == WAIT) || (state == GAP));
  assign busy        = (state != IDLE) || !fifo_empty;

  // With no volume port, vol_reg stays 0 and the shift is a pass-through.
  always_comb begin
    codec_data = SAMPLE_W'(SILENCE);
    if (state == WAIT) codec_data = SAMPLE_W'($signed(sample_reg) >>> vol_reg);
  end

endmodule

// File: tb/tb_audio_clip_sequencer.sv
// Directed self-checking bench for audio_clip_sequencer (GAP_SAMPLES = 2);
// exercises the volume path as well when AUDIO_SEQ_VOLUME_EN is defined.
module tb_audio_clip_sequencer;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [15:0] req_clip = '0;
  logic        flush = 1'b0;
  logic [15:0] clip_base;
  logic [15:0] clip_len;
  logic [15:0] rom_addr;
  logic [23:0] rom_data;
  logic        codec_write_ready = 1'b0;
  logic        codec_write;
  logic [23:0] codec_data;
  logic [3:0]  cur_clip;
  logic        busy;
  logic        clip_done;
  logic [2:0]  queue_level;
  logic        overflow;
`ifdef AUDIO_SEQ_VOLUME_EN
  logic [2:0]  volume = 3'd0;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  logic [23:0] wr_q[$];

  always #5 CLOCK_50 = ~CLOCK_50;

  audio_clip_sequencer #(
    .NUM_SRC(4), .CLIP_W(4), .ADDR_W(16), .SAMPLE_W(24),
    .QUEUE_DEPTH(4), .GAP_SAMPLES(2)
  ) dut (
    .CLOCK_50          (CLOCK_50),
    .reset             (reset),
`ifdef AUDIO_SEQ_VOLUME_EN
    .volume            (volume),
`endif
    .req_valid         (req_valid),
    .req_clip          (req_clip),
    .flush             (flush),
    .clip_base         (clip_base),
    .clip_len          (clip_len),
    .rom_addr          (rom_addr),
    .rom_data          (rom_data),
    .codec_write_ready (codec_write_ready),
    .codec_write       (codec_write),
    .codec_data        (codec_data),
    .cur_clip          (cur_clip),
    .busy              (busy),
    .clip_done         (clip_done),
    .queue_level       (queue_level),
    .overflow          (overflow)
  );

  // Clip table and ROM contents: sample at address A is {8'h5A, A}, except 0x700.
  always_comb begin
    case (cur_clip)
      4'd1:    begin clip_base = 16'h0200; clip_len = 16'd2; end
      4'd2:    begin clip_base = 16'h0300; clip_len = 16'd1; end
      4'd3:    begin clip_base = 16'h0100; clip_len = 16'd4; end
      4'd4:    begin clip_base = 16'h0400; clip_len = 16'd8; end
      4'd5:    begin clip_base = 16'h0500; clip_len = 16'd0; end
      4'd6:    begin clip_base = 16'h0600; clip_len = 16'd3; end
      4'd7:    begin clip_base = 16'h0700; clip_len = 16'd1; end
      default: begin clip_base = 16'h0000; clip_len = 16'd1; end
    endcase
    rom_data = (rom_addr == 16'h0700) ? 24'h800000 : {8'h5A, rom_addr};
  end

  // Record every accepted CODEC write and every clip_done pulse.
  always @(negedge CLOCK_50) begin
    if (codec_write) wr_q.push_back(codec_data);
    if (clip_done)   done_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [15:0] clips);
    req_valid = v;
    req_clip  = clips;
    tick(1);
    req_valid = '0;
  endtask

  task automatic readyPulses(input int n, input int spacing);
    repeat (n) begin
      tick(spacing);
      codec_write_ready = 1'b1;
      tick(1);
      codec_write_ready = 1'b0;
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    req_valid = '0;
    flush = 1'b0;
    codec_write_ready = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_rom_addr"}, 32'(rom_addr), 32'h0);
    checkOutput({tag, "_cur_clip"}, 32'(cur_clip), 32'h0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
    checkOutput({tag, "_clip_done"}, 32'(clip_done), 32'h0);
    checkOutput({tag, "_overflow"}, 32'(overflow), 32'h0);
    checkOutput({tag, "_level"}, 32'(queue_level), 32'h0);
    checkOutput({tag, "_data"}, 32'(codec_data), 32'h0);
    checkOutput({tag, "_write"}, 32'(codec_write), 32'h0);
  endtask

  initial begin
    int base;
    int dsnap;
    int exp_len [5];
    int exp_base[5];
    int k;

    $display("[TB] start");
    doReset();
    checkReset("rst");

    // Single clip 3: four ROM samples, then two silent gap writes.
    applyStimulus(4'b0001, 16'h0003);
    checkOutput("t1_level", 32'(queue_level), 32'd1);
    tick(1);
    checkOutput("t1_cur_clip", 32'(cur_clip), 32'd3);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    base = wr_q.size();
    dsnap = done_cnt;
    readyPulses(3, 9);
    checkOutput("t1_done_before_last", 32'(done_cnt - dsnap), 32'd0);
    readyPulses(3, 9);
    checkOutput("t1_nwrites", 32'(wr_q.size() - base), 32'd6);
    checkOutput("t1_w0", 32'(wr_q[base+0]), 32'h5A0100);
    checkOutput("t1_w1", 32'(wr_q[base+1]), 32'h5A0101);
    checkOutput("t1_w2", 32'(wr_q[base+2]), 32'h5A0102);
    checkOutput("t1_w3", 32'(wr_q[base+3]), 32'h5A0103);
    checkOutput("t1_gap0", 32'(wr_q[base+4]), 32'h0);
    checkOutput("t1_gap1", 32'(wr_q[base+5]), 32'h0);
    checkOutput("t1_done_cnt", 32'(done_cnt - dsnap), 32'd1);
    checkOutput("t1_busy_end", 32'(busy), 32'd0);
    checkOutput("t1_overflow", 32'(overflow), 32'd0);

    // Two simultaneous requests: source 1 wins, source 2 is dropped.
    applyStimulus(4'b0110, 16'h0210);
    checkOutput("t2_level", 32'(queue_level), 32'd1);
    checkOutput("t2_overflow", 32'(overflow), 32'd1);
    tick(1);
    checkOutput("t2_cur_clip", 32'(cur_clip), 32'd1);
    base = wr_q.size();
    readyPulses(4, 9);
    checkOutput("t2_w0", 32'(wr_q[base+0]), 32'h5A0200);
    checkOutput("t2_w1", 32'(wr_q[base+1]), 32'h5A0201);
    checkOutput("t2_busy_end", 32'(busy), 32'd0);

    // Fill the queue behind a playing clip; the fifth request overflows.
    doReset();
    applyStimulus(4'b0001, 16'h0004);
    tick(3);
    applyStimulus(4'b0001, 16'h0001);
    applyStimulus(4'b0001, 16'h0002);
    applyStimulus(4'b0001, 16'h0006);
    applyStimulus(4'b0001, 16'h0003);
    checkOutput("t3_level_full", 32'(queue_level), 32'd4);
    checkOutput("t3_no_overflow_yet", 32'(overflow), 32'd0);
    applyStimulus(4'b0001, 16'h0007);
    checkOutput("t3_level_after_drop", 32'(queue_level), 32'd4);
    checkOutput("t3_overflow", 32'(overflow), 32'd1);
    exp_base = '{32'h400, 32'h200, 32'h300, 32'h600, 32'h100};
    exp_len  = '{8, 2, 1, 3, 4};
    base = wr_q.size();
    dsnap = done_cnt;
    readyPulses(28, 9);
    checkOutput("t3_nwrites", 32'(wr_q.size() - base), 32'd28);
    checkOutput("t3_done_cnt", 32'(done_cnt - dsnap), 32'd5);
    k = base;
    for (int c = 0; c < 5; c++) begin
      for (int s = 0; s < exp_len[c]; s++) begin
        checkOutput($sformatf("t3_c%0d_s%0d", c, s), 32'(wr_q[k]),
                    {8'h0, 8'h5A, 16'(exp_base[c] + s)});
        k++;
      end
      checkOutput($sformatf("t3_c%0d_gap0", c), 32'(wr_q[k]), 32'h0);
      checkOutput($sformatf("t3_c%0d_gap1", c), 32'(wr_q[k+1]), 32'h0);
      k += 2;
    end
    checkOutput("t3_busy_end", 32'(busy), 32'd0);

    // Flush in the middle of an 8-sample clip with two clips queued.
    doReset();
    applyStimulus(4'b0001, 16'h0004);
    applyStimulus(4'b0001, 16'h0001);
    applyStimulus(4'b0001, 16'h0002);
    checkOutput("t4_level_pre", 32'(queue_level), 32'd2);
    readyPulses(2, 9);
    tick(3);
    dsnap = done_cnt;
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    checkOutput("t4_level", 32'(queue_level), 32'd0);
    checkOutput("t4_busy", 32'(busy), 32'd0);
    base = wr_q.size();
    readyPulses(1, 3);
    checkOutput("t4_next_write", 32'(wr_q[base]), 32'h0);
    checkOutput("t4_no_done", 32'(done_cnt - dsnap), 32'd0);
    flush = 1'b1;
    applyStimulus(4'b0011, 16'h0021);
    flush = 1'b0;
    checkOutput("t4_flush_push_level", 32'(queue_level), 32'd0);
    checkOutput("t4_flush_push_ovf", 32'(overflow), 32'd0);

    // Zero-length clip: done pulse in DESC, no samples, next clip follows.
    doReset();
    dsnap = done_cnt;
    applyStimulus(4'b0001, 16'h0005);
    applyStimulus(4'b0001, 16'h0002);
    checkOutput("t5_cur_clip", 32'(cur_clip), 32'd5);
    checkOutput("t5_done_in_desc", 32'(clip_done), 32'd1);
    base = wr_q.size();
    readyPulses(3, 9);
    checkOutput("t5_nwrites", 32'(wr_q.size() - base), 32'd3);
    checkOutput("t5_w0", 32'(wr_q[base]), 32'h5A0300);
    checkOutput("t5_gap", 32'(wr_q[base+1]), 32'h0);
    checkOutput("t5_done_cnt", 32'(done_cnt - dsnap), 32'd2);

    // Negative full-scale sample, scaled by volume 3 when the feature is built.
    doReset();
`ifdef AUDIO_SEQ_VOLUME_EN
    volume = 3'd3;
`endif
    applyStimulus(4'b0001, 16'h0007);
    base = wr_q.size();
    readyPulses(1, 9);
`ifdef AUDIO_SEQ_VOLUME_EN
    checkOutput("t6_volume", 32'(wr_q[base]), 32'hF00000);
`else
    checkOutput("t6_unscaled", 32'(wr_q[base]), 32'h800000);
`endif

    // Reset in the middle of a clip returns every output to its reset value.
    doReset();
    applyStimulus(4'b0001, 16'h0004);
    applyStimulus(4'b0001, 16'h0006);
    readyPulses(1, 9);
    tick(3);
    checkOutput("t7_busy_mid", 32'(busy), 32'd1);
    doReset();
    checkReset("t7_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
